// File: rtl/avalon_uart_master.sv
`default_nettype none
// ============================================================================
//  Module      : avalon_uart_master
//  Description : Avalon-MM master that initialises a 16550-style UART, then
//                polls LSR and moves bytes between the UART and a pair of
//                one-byte TX/RX stream buffers.
//  Revision    : 1.0 - initial release
// ============================================================================
module avalon_uart_master #(
   parameter logic [15:0] DIVISOR   = 16'h001B,
   parameter logic [7:0]  LCR_VALUE = 8'h03,
   parameter logic [7:0]  FCR_VALUE = 8'h07
) (
   input  logic       avc_c1_clk,
   input  logic       avc_c1_reset_n,
   // Avalon-MM master towards the UART register file
   output logic [4:0] avm_m1_address,
   output logic [7:0] avm_m1_writedata,
   output logic       avm_m1_write,
   output logic       avm_m1_read,
   input  logic       avm_m1_waitrequest,
   input  logic [7:0] avm_m1_readdata,
   // TX byte stream sink
   input  logic [7:0] asi_tx_data,
   input  logic       asi_tx_valid,
   output logic       asi_tx_ready,
   // RX byte stream source
   output logic [7:0] aso_rx_data,
   output logic       aso_rx_valid,
   input  logic       aso_rx_ready,
   // status
   output logic       init_done,
   output logic       line_err
);

   // UART register byte addresses (register n lives at n<<2)
   localparam logic [4:0] C_ADDR_RBR_THR = 5'h00;
   localparam logic [4:0] C_ADDR_DLM     = 5'h04;
   localparam logic [4:0] C_ADDR_FCR     = 5'h08;
   localparam logic [4:0] C_ADDR_LCR     = 5'h0C;
   localparam logic [4:0] C_ADDR_LSR     = 5'h14;
   localparam logic [7:0] C_LCR_DLAB     = 8'h80;

   typedef enum logic [3:0] {
      S_INIT_LCRD = 4'd0,
      S_INIT_DLL  = 4'd1,
      S_INIT_DLM  = 4'd2,
      S_INIT_LCR  = 4'd3,
      S_INIT_FCR  = 4'd4,
      S_POLL      = 4'd5,
      S_LSR_WAIT  = 4'd6,
      S_RBR       = 4'd7,
      S_RBR_WAIT  = 4'd8,
      S_THR       = 4'd9
   } state_t;

   state_t     r_state;
   logic [4:0] r_address;
   logic [7:0] r_writedata;
   logic       r_write;
   logic       r_read;
   logic       r_init_done;
   logic       r_line_err;
   logic [7:0] r_rx_data;
   logic       r_rx_valid;
   logic [7:0] r_tx_data;
   logic       r_tx_full;
   logic       r_tx_ready;

   logic       w_bus_state;
   logic       w_req_write;
   logic [4:0] w_req_address;
   logic [7:0] w_req_data;
   state_t     w_after_state;
   logic       w_accept;
   logic       w_thr_accept;
   logic       w_fcr_accept;
   logic       w_tx_take;
   logic       w_tx_full_next;
   logic       w_init_done_next;

   // Decode the bus transaction each issuing state performs and where it goes next
   always_comb begin
      w_bus_state   = 1'b1;
      w_req_write   = 1'b1;
      w_req_address = C_ADDR_RBR_THR;
      w_req_data    = 8'h00;
      w_after_state = S_POLL;
      case (r_state)
         S_INIT_LCRD: begin
            w_req_address = C_ADDR_LCR;
            w_req_data    = LCR_VALUE | C_LCR_DLAB;
            w_after_state = S_INIT_DLL;
         end
         S_INIT_DLL: begin
            w_req_address = C_ADDR_RBR_THR;
            w_req_data    = DIVISOR[7:0];
            w_after_state = S_INIT_DLM;
         end
         S_INIT_DLM: begin
            w_req_address = C_ADDR_DLM;
            w_req_data    = DIVISOR[15:8];
            w_after_state = S_INIT_LCR;
         end
         S_INIT_LCR: begin
            w_req_address = C_ADDR_LCR;
            w_req_data    = LCR_VALUE;
            w_after_state = S_INIT_FCR;
         end
         S_INIT_FCR: begin
            w_req_address = C_ADDR_FCR;
            w_req_data    = FCR_VALUE;
            w_after_state = S_POLL;
         end
         S_POLL: begin
            w_req_write   = 1'b0;
            w_req_address = C_ADDR_LSR;
            w_after_state = S_LSR_WAIT;
         end
         S_RBR: begin
            w_req_write   = 1'b0;
            w_req_address = C_ADDR_RBR_THR;
            w_after_state = S_RBR_WAIT;
         end
         S_THR: begin
            w_req_address = C_ADDR_RBR_THR;
            w_req_data    = r_tx_data;
            w_after_state = S_POLL;
         end
         default: begin
            w_bus_state = 1'b0;
         end
      endcase
   end

   // Strobes are only ever high in issuing states, so acceptance needs no state qualifier
   assign w_accept         = (r_read | r_write) & ~avm_m1_waitrequest;
   assign w_thr_accept     = w_accept & (r_state == S_THR);
   assign w_fcr_accept     = w_accept & (r_state == S_INIT_FCR);
   assign w_tx_take        = asi_tx_valid & r_tx_ready;
   // A take needs ready, which implies the buffer is empty, so it never meets a THR accept
   assign w_tx_full_next   = w_tx_take | (r_tx_full & ~w_thr_accept);
   assign w_init_done_next = r_init_done | w_fcr_accept;

   // Main sequencer: init writes, LSR polling, RBR reads, THR writes
   always_ff @(posedge avc_c1_clk or negedge avc_c1_reset_n) begin
      if (!avc_c1_reset_n) begin
         r_state     <= S_INIT_LCRD;
         r_address   <= 5'h00;
         r_writedata <= 8'h00;
         r_write     <= 1'b0;
         r_read      <= 1'b0;
         r_init_done <= 1'b0;
         r_line_err  <= 1'b0;
         r_rx_data   <= 8'h00;
         r_rx_valid  <= 1'b0;
      end else begin
         if (r_rx_valid && aso_rx_ready) begin
            r_rx_valid <= 1'b0;
         end
         case (r_state)
            S_LSR_WAIT: begin
               if (|avm_m1_readdata[4:1]) begin
                  r_line_err <= 1'b1;
               end
               // Receive has priority; a full RX buffer leaves bytes in the UART FIFO
               if (avm_m1_readdata[0] && !r_rx_valid) begin
                  r_state <= S_RBR;
               end else if (avm_m1_readdata[5] && r_tx_full) begin
                  r_state <= S_THR;
               end else begin
                  r_state <= S_POLL;
               end
            end
            S_RBR_WAIT: begin
               r_rx_data  <= avm_m1_readdata;
               r_rx_valid <= 1'b1;
               r_state    <= S_POLL;
            end
            default: begin
               if (!w_bus_state) begin
                  r_state <= S_INIT_LCRD;
               end else if (!(r_read || r_write)) begin
                  // First cycle in an issuing state: launch the request
                  r_address   <= w_req_address;
                  r_writedata <= w_req_data;
                  r_write     <= w_req_write;
                  r_read      <= ~w_req_write;
               end else if (!avm_m1_waitrequest) begin
                  // Accepted: drop strobes, leaving an idle cycle before any readdata sample
                  r_write <= 1'b0;
                  r_read  <= 1'b0;
                  r_state <= w_after_state;
                  if (w_fcr_accept) begin
                     r_init_done <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

   // One-byte TX buffer with a registered ready that mirrors next-cycle occupancy
   always_ff @(posedge avc_c1_clk or negedge avc_c1_reset_n) begin
      if (!avc_c1_reset_n) begin
         r_tx_data  <= 8'h00;
         r_tx_full  <= 1'b0;
         r_tx_ready <= 1'b0;
      end else begin
         if (w_tx_take) begin
            r_tx_data <= asi_tx_data;
         end
         r_tx_full  <= w_tx_full_next;
         r_tx_ready <= w_init_done_next & ~w_tx_full_next;
      end
   end

   assign avm_m1_address   = r_address;
   assign avm_m1_writedata = r_writedata;
   assign avm_m1_write     = r_write;
   assign avm_m1_read      = r_read;
   assign asi_tx_ready     = r_tx_ready;
   assign aso_rx_data      = r_rx_data;
   assign aso_rx_valid     = r_rx_valid;
   assign init_done        = r_init_done;
   assign line_err         = r_line_err;

endmodule
`default_nettype wire

// File: tb/tb_avalon_uart_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_avalon_uart_master
//  Description : Self-checking bench for avalon_uart_master with a UART
//                register-file slave model and randomized stream bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_avalon_uart_master;

   localparam logic [15:0] DIVISOR   = 16'h001B;
   localparam logic [7:0]  LCR_VALUE = 8'h03;
   localparam logic [7:0]  FCR_VALUE = 8'h07;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] avm_m1_address;
   logic [7:0] avm_m1_writedata;
   logic       avm_m1_write;
   logic       avm_m1_read;
   logic       wait_r = 1'b0;
   logic [7:0] avm_m1_readdata = 8'h00;
   logic [7:0] asi_tx_data = 8'h00;
   logic       asi_tx_valid = 1'b0;
   logic       asi_tx_ready;
   logic [7:0] aso_rx_data;
   logic       aso_rx_valid;
   logic       aso_rx_ready = 1'b1;
   logic       init_done;
   logic       line_err;

   always #5 clk = ~clk;

   avalon_uart_master #(
      .DIVISOR   (DIVISOR),
      .LCR_VALUE (LCR_VALUE),
      .FCR_VALUE (FCR_VALUE)
   ) dut (
      .avc_c1_clk         (clk),
      .avc_c1_reset_n     (rst_n),
      .avm_m1_address     (avm_m1_address),
      .avm_m1_writedata   (avm_m1_writedata),
      .avm_m1_write       (avm_m1_write),
      .avm_m1_read        (avm_m1_read),
      .avm_m1_waitrequest (wait_r),
      .avm_m1_readdata    (avm_m1_readdata),
      .asi_tx_data        (asi_tx_data),
      .asi_tx_valid       (asi_tx_valid),
      .asi_tx_ready       (asi_tx_ready),
      .aso_rx_data        (aso_rx_data),
      .aso_rx_valid       (aso_rx_valid),
      .aso_rx_ready       (aso_rx_ready),
      .init_done          (init_done),
      .line_err           (line_err)
   );

   typedef struct packed {
      logic       wr;
      logic [4:0] addr;
      logic [7:0] data;
   } txn_t;

   txn_t       txn_q[$];
   logic [7:0] lsr_q[$];
   logic [7:0] rbr_q[$];
   logic [7:0] rx_got[$];
   txn_t       exp_init[5];

   int total = 0;
   int bad = 0;
   int stall_target = 0;
   int stall_done = 0;
   int stall_seen = 0;
   int rx_valid_cycles = 0;
   logic       held_valid = 1'b0;
   logic [4:0] held_addr = 5'h00;
   logic [7:0] held_data = 8'h00;
   logic       held_wr = 1'b0;
   logic       tx_busy = 1'b0;
   logic       fcr_pending = 1'b0;
   logic       thr_now;
   logic [7:0] resp;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int find_txn(input int from, input logic wr, input logic [4:0] a);
      for (int i = from; i < txn_q.size(); i++) begin
         if (txn_q[i].wr == wr && txn_q[i].addr == a) return i;
      end
      return -1;
   endfunction

   function automatic int count_txn(input int from, input logic wr, input logic [4:0] a);
      int n = 0;
      for (int i = from; i < txn_q.size(); i++) begin
         if (txn_q[i].wr == wr && txn_q[i].addr == a) n++;
      end
      return n;
   endfunction

   // UART slave model plus stream monitors, all evaluated mid-cycle
   always @(negedge clk) begin
      if (fcr_pending) begin
         chk("init_done_rise", {31'd0, init_done}, 32'd1);
         fcr_pending = 1'b0;
      end
      if (held_valid) begin
         chk("hold_addr", {27'd0, avm_m1_address}, {27'd0, held_addr});
         chk("hold_data", {24'd0, avm_m1_writedata}, {24'd0, held_data});
         chk("hold_strobes", {30'd0, avm_m1_write, avm_m1_read}, {30'd0, held_wr, ~held_wr});
      end
      held_valid = 1'b0;
      thr_now    = 1'b0;
      if (rst_n && (avm_m1_read || avm_m1_write)) begin
         if (stall_done < stall_target) begin
            stall_done++;
            stall_seen++;
            wait_r     = 1'b1;
            held_valid = 1'b1;
            held_addr  = avm_m1_address;
            held_data  = avm_m1_writedata;
            held_wr    = avm_m1_write;
         end else begin
            wait_r = 1'b0;
            if (avm_m1_write) begin
               txn_q.push_back('{1'b1, avm_m1_address, avm_m1_writedata});
               if (avm_m1_address == 5'h08) begin
                  chk("init_done_before_fcr", {31'd0, init_done}, 32'd0);
                  fcr_pending = 1'b1;
               end
               if (avm_m1_address == 5'h00) thr_now = 1'b1;
            end else begin
               resp = 8'h00;
               if (avm_m1_address == 5'h14 && lsr_q.size() > 0) resp = lsr_q.pop_front();
               else if (avm_m1_address == 5'h00 && rbr_q.size() > 0) resp = rbr_q.pop_front();
               avm_m1_readdata = resp;
               txn_q.push_back('{1'b0, avm_m1_address, resp});
            end
         end
      end else begin
         wait_r = 1'b0;
      end
      if (aso_rx_valid) rx_valid_cycles++;
      if (aso_rx_valid && aso_rx_ready) rx_got.push_back(aso_rx_data);
      if (tx_busy) chk("tx_ready_low_while_busy", {31'd0, asi_tx_ready}, 32'd0);
      if (tx_busy && thr_now) tx_busy = 1'b0;
      else if (asi_tx_valid && asi_tx_ready) tx_busy = 1'b1;
   end

   task automatic wait_txn_count(input int n, input string tag);
      int k = 0;
      while (txn_q.size() < n && k < 2000) begin tick(); k++; end
      chk(tag, {31'd0, txn_q.size() >= n}, 32'd1);
   endtask

   task automatic wait_rx_count(input int n, input string tag);
      int k = 0;
      while (rx_got.size() < n && k < 2000) begin tick(); k++; end
      chk(tag, {31'd0, rx_got.size() >= n}, 32'd1);
   endtask

   task automatic wait_lsr_empty();
      int k = 0;
      while (lsr_q.size() > 0 && k < 2000) begin tick(); k++; end
      chk("lsr_consumed", {31'd0, lsr_q.size() == 0}, 32'd1);
   endtask

   task automatic wait_find(input int from, input logic wr, input logic [4:0] a, input string tag);
      int k = 0;
      while (find_txn(from, wr, a) < 0 && k < 2000) begin tick(); k++; end
      chk(tag, {31'd0, find_txn(from, wr, a) >= 0}, 32'd1);
   endtask

   task automatic send_tx(input logic [7:0] b);
      int k = 0;
      asi_tx_data  = b;
      asi_tx_valid = 1'b1;
      while (!asi_tx_ready && k < 500) begin tick(); k++; end
      chk("tx_ready_timeout", {31'd0, asi_tx_ready}, 32'd1);
      tick();
      asi_tx_valid = 1'b0;
   endtask

   task automatic check_init(input int base, input string tag);
      wait_txn_count(base + 6, {tag, "_timeout"});
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("%s_write%0d", tag, i), {18'd0, txn_q[base + i]}, {18'd0, exp_init[i]});
      end
      chk({tag, "_first_poll"}, {18'd0, txn_q[base + 5]}, {18'd0, 1'b0, 5'h14, 8'h00});
      chk({tag, "_init_done"}, {31'd0, init_done}, 32'd1);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_write"}, {31'd0, avm_m1_write}, 32'd0);
      chk({tag, "_read"}, {31'd0, avm_m1_read}, 32'd0);
      chk({tag, "_address"}, {27'd0, avm_m1_address}, 32'd0);
      chk({tag, "_writedata"}, {24'd0, avm_m1_writedata}, 32'd0);
      chk({tag, "_rx_valid"}, {31'd0, aso_rx_valid}, 32'd0);
      chk({tag, "_rx_data"}, {24'd0, aso_rx_data}, 32'd0);
      chk({tag, "_tx_ready"}, {31'd0, asi_tx_ready}, 32'd0);
      chk({tag, "_init_done"}, {31'd0, init_done}, 32'd0);
      chk({tag, "_line_err"}, {31'd0, line_err}, 32'd0);
   endtask

   int         base;
   int         nrx;
   int         vc;
   int         ir;
   int         iw;
   int         k;
   logic [7:0] b;
   logic [7:0] t;
   logic [7:0] lsr;

   initial begin
      exp_init[0] = '{1'b1, 5'h0C, LCR_VALUE | 8'h80};
      exp_init[1] = '{1'b1, 5'h00, DIVISOR[7:0]};
      exp_init[2] = '{1'b1, 5'h04, DIVISOR[15:8]};
      exp_init[3] = '{1'b1, 5'h0C, LCR_VALUE};
      exp_init[4] = '{1'b1, 5'h08, FCR_VALUE};

      // Reset state, with the first init write set up to be stalled 3 cycles
      stall_target = 3;
      repeat (3) tick();
      check_reset_values("reset");
      rst_n = 1'b1;
      #3;
      chk("no_strobe_before_edge", {31'd0, avm_m1_write | avm_m1_read}, 32'd0);

      // Streams stay quiet until init completes
      k = 0;
      while (!init_done && k < 200) begin
         chk("pre_init_tx_ready", {31'd0, asi_tx_ready}, 32'd0);
         chk("pre_init_rx_valid", {31'd0, aso_rx_valid}, 32'd0);
         tick();
         k++;
      end
      check_init(0, "init");
      chk("stall_cycles", stall_seen, 32'd3);

      // Random RX bytes with ready held high
      for (int n = 0; n < 4; n++) begin
         b    = 8'($urandom);
         lsr  = 8'h01 | (8'($urandom) & 8'hE0);
         base = txn_q.size();
         nrx  = rx_got.size();
         vc   = rx_valid_cycles;
         lsr_q.push_back(lsr);
         rbr_q.push_back(b);
         wait_rx_count(nrx + 1, "rx_timeout");
         repeat (6) tick();
         chk("rx_data", {24'd0, rx_got[nrx]}, {24'd0, b});
         chk("rx_valid_one_cycle", vc + 1, rx_valid_cycles);
         ir = find_txn(base, 1'b0, 5'h00);
         chk("rbr_read_seen", {31'd0, ir > 0}, 32'd1);
         chk("rbr_after_lsr", {18'd0, txn_q[ir - 1]}, {18'd0, 1'b0, 5'h14, lsr});
         chk("poll_after_rbr", {30'd0, txn_q[ir + 1].wr, txn_q[ir + 1].addr == 5'h14}, 32'd1);
      end

      // TX byte waits for LSR[5], then a single THR write
      t    = 8'($urandom);
      base = txn_q.size();
      send_tx(t);
      chk("tx_ready_after_latch", {31'd0, asi_tx_ready}, 32'd0);
      repeat (10) tick();
      chk("no_thr_without_thre", find_txn(base, 1'b1, 5'h00), -1);
      lsr_q.push_back(8'h20);
      wait_find(base, 1'b1, 5'h00, "thr_timeout");
      repeat (4) tick();
      iw = find_txn(base, 1'b1, 5'h00);
      chk("thr_data", {24'd0, txn_q[iw].data}, {24'd0, t});
      chk("thr_single", count_txn(base, 1'b1, 5'h00), 32'd1);
      chk("tx_ready_after_thr", {31'd0, asi_tx_ready}, 32'd1);

      // Both eligible: RBR read must precede the THR write
      t    = 8'($urandom);
      b    = 8'($urandom);
      nrx  = rx_got.size();
      send_tx(t);
      repeat (2) tick();
      base = txn_q.size();
      lsr_q.push_back(8'h21);
      lsr_q.push_back(8'h20);
      rbr_q.push_back(b);
      wait_find(base, 1'b1, 5'h00, "prio_thr_timeout");
      ir = find_txn(base, 1'b0, 5'h00);
      iw = find_txn(base, 1'b1, 5'h00);
      chk("rx_before_tx", {31'd0, ir >= 0 && ir < iw}, 32'd1);
      chk("prio_thr_data", {24'd0, txn_q[iw].data}, {24'd0, t});
      wait_rx_count(nrx + 1, "prio_rx_timeout");
      chk("prio_rx_data", {24'd0, rx_got[nrx]}, {24'd0, b});

      // RX backpressure: pending byte blocks further RBR reads; line error is sticky
      aso_rx_ready = 1'b0;
      b    = 8'($urandom);
      base = txn_q.size();
      nrx  = rx_got.size();
      chk("line_err_clear", {31'd0, line_err}, 32'd0);
      lsr_q.push_back(8'h01);
      rbr_q.push_back(b);
      k = 0;
      while (!aso_rx_valid && k < 500) begin tick(); k++; end
      chk("bp_rx_valid_timeout", {31'd0, aso_rx_valid}, 32'd1);
      repeat (4) lsr_q.push_back(8'h01);
      wait_lsr_empty();
      repeat (6) tick();
      chk("bp_single_rbr", count_txn(base, 1'b0, 5'h00), 32'd1);
      chk("bp_rx_held", {31'd0, aso_rx_valid}, 32'd1);
      chk("bp_rx_data", {24'd0, aso_rx_data}, {24'd0, b});
      chk("bp_line_err_clear", {31'd0, line_err}, 32'd0);
      lsr_q.push_back(8'h09);
      wait_lsr_empty();
      repeat (4) tick();
      chk("line_err_set", {31'd0, line_err}, 32'd1);
      repeat (20) tick();
      chk("line_err_sticky", {31'd0, line_err}, 32'd1);
      chk("bp_still_single_rbr", count_txn(base, 1'b0, 5'h00), 32'd1);
      aso_rx_ready = 1'b1;
      repeat (2) tick();
      chk("bp_rx_count", rx_got.size(), nrx + 1);
      chk("bp_rx_released", {24'd0, rx_got[nrx]}, {24'd0, b});

      // Asynchronous reset while waiting for RBR data
      b    = 8'($urandom);
      base = txn_q.size();
      nrx  = rx_got.size();
      lsr_q.push_back(8'h01);
      rbr_q.push_back(b);
      k = 0;
      while (find_txn(base, 1'b0, 5'h00) < 0 && k < 500) begin tick(); k++; end
      chk("rbr_wait_reached", {31'd0, find_txn(base, 1'b0, 5'h00) >= 0}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_values("async_reset");
      repeat (3) tick();
      base  = txn_q.size();
      rst_n = 1'b1;
      #3;
      chk("rerelease_no_strobe", {31'd0, avm_m1_write | avm_m1_read}, 32'd0);
      check_init(base, "reinit");
      chk("abandoned_rx", rx_got.size(), nrx);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/avalon_uart_master.md
AVALON_UART_MASTER -- requirements
Module: avalon_uart_master

Interface
REQ-001 Parameter DIVISOR, 16'h001B, baud divisor programmed into DLL/DLM at init.
REQ-002 Parameter LCR_VALUE, 8'h03, line control value written after divisor (8N1).
REQ-003 Parameter FCR_VALUE, 8'h07, FIFO control value written at init (enable, clear both FIFOs).
REQ-004 avc_c1_clk  in  1  sole clock; all state changes on rising edge.
REQ-005 avc_c1_reset_n  in  1  one clock; reset asynchronous, active-low.
REQ-006 avm_m1_address  out  5  byte address; UART register n at n<<2.
REQ-007 avm_m1_writedata  out  8  write byte.
REQ-008 avm_m1_write / avm_m1_read  out  1 each  Avalon-MM master strobes.
REQ-009 avm_m1_waitrequest  in  1  slave stall.
REQ-010 avm_m1_readdata  in  8  read byte, valid exactly 1 cycle after read accepted.
REQ-011 asi_tx_data / asi_tx_valid / asi_tx_ready  in 8 / in 1 / out 1  TX byte stream sink.
REQ-012 aso_rx_data / aso_rx_valid / aso_rx_ready  out 8 / out 1 / in 1  RX byte stream source.
REQ-013 init_done  out  1  high once init sequence complete.
REQ-014 line_err  out  1  sticky: any LSR[4:1] bit seen set.

Function
REQ-015 Transaction accepted on cycle where (read|write)=1 and avm_m1_waitrequest=0; address, writedata, strobes held stable while waitrequest=1.
REQ-016 read and write never asserted together; at most one outstanding transaction; no new strobe in the cycle readdata is sampled.
REQ-017 Init writes in order: 0x0C<-LCR_VALUE|0x80, 0x00<-DIVISOR[7:0], 0x04<-DIVISOR[15:8], 0x0C<-LCR_VALUE, 0x08<-FCR_VALUE; one state per write (INIT_LCRD, INIT_DLL, INIT_DLM, INIT_LCR, INIT_FCR).
REQ-018 init_done rises the cycle after the FCR write is accepted; stays high until reset.
REQ-019 Run states: POLL (read 0x14), LSR_WAIT, RBR (read 0x00), RBR_WAIT, THR (write 0x00).
REQ-020 After LSR sampled: LSR[0]=1 and RX buffer empty -> RBR; else LSR[5]=1 and TX buffer full -> THR; else -> POLL next cycle.
REQ-021 RX beats TX when both eligible; after RBR or THR completes, return to POLL.
REQ-022 RX buffer: one byte; RBR_WAIT captures readdata into aso_rx_data, sets aso_rx_valid; cleared when aso_rx_valid&aso_rx_ready.
REQ-023 While aso_rx_valid=1, RBR never read (backpressure holds bytes in UART FIFO).
REQ-024 TX buffer: one byte; asi_tx_ready = !tx_full & init_done; byte latched on asi_tx_valid&asi_tx_ready; freed when THR write accepted.
REQ-025 Byte may be accepted into TX buffer in the same cycle the previous one's THR write is accepted only if ready was high that cycle (ready is registered, no combinational path from waitrequest).
REQ-026 line_err set in LSR_WAIT if readdata[4:1]!=0; never cleared except by reset.
REQ-027 Before init_done, stream interfaces inactive: asi_tx_ready=0, aso_rx_valid=0.

Reset
REQ-028 On reset_n low, immediately: read=0, write=0, address=0, writedata=0, aso_rx_valid=0, aso_rx_data=0, asi_tx_ready=0, init_done=0, line_err=0, buffers empty, state INIT_LCRD.
REQ-029 Reset asserted mid-transaction abandons it; on release, init sequence restarts from REQ-017, first write no earlier than first rising edge after release.

Verification
REQ-030 DIVISOR=16'h001B, no waitrequest: writes (0x0C,0x83),(0x00,0x1B),(0x04,0x00),(0x0C,0x03),(0x08,0x07) in order -> init_done=1, first read to 0x14 follows.
REQ-031 LSR returns 0x01 then RBR 0x5A, aso_rx_ready=1 -> aso_rx_valid=1 with 0x5A for one cycle; next transaction is read of 0x14.
REQ-032 waitrequest=1 for 3 cycles on an init write -> address/writedata/write unchanged all 4 cycles; sequence resumes on acceptance.
REQ-033 Send 0xA5 on TX, LSR=0x20 -> single write (0x00,0xA5); asi_tx_ready low from latch until write accepted; LSR=0x21 with free RX buffer -> RBR read before THR write.
REQ-034 aso_rx_ready=0 with byte pending, LSR=0x01 repeated -> only 0x14 reads issued; LSR=0x09 -> line_err=1 and stays 1.
REQ-035 Assert reset_n low during RBR_WAIT -> all outputs at REQ-028 values asynchronously; after release full init sequence repeats.
